// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, es->ms bus field offsets, FSM encoding and
// a bus unpack helper for the memory stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 215;
  localparam int MS_TO_WS_BUS_WD = 71;
  localparam int MS_FWD_BUS_WD   = 39;

  // es_to_ms_bus field offsets
  localparam int ES_PC_LSB       = 0;
  localparam int ES_RESULT_LSB   = 32;
  localparam int ES_DEST_LSB     = 64;
  localparam int ES_GR_WE_BIT    = 69;
  localparam int ES_LOAD_BIT     = 70;
  localparam int ES_SIZE_LSB     = 75;
  localparam int ES_EXCP_BIT     = 77;
  localparam int ES_STORE_BIT    = 171;
  localparam int ES_SIGN_BIT     = 207;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,   // no data pending
    MS_WAIT = 2'd1,   // request issued, response not yet seen
    MS_HOLD = 2'd2    // response captured in rdata_buf
  } ms_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] exe_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        load_op;
    logic        store_op;
    logic [1:0]  mem_size;
    logic        excp;
    logic        mem_sign_exted;
  } es_fields_t;

  function automatic es_fields_t es_unpack(input logic [ES_TO_MS_BUS_WD-1:0] b);
    es_fields_t f;
    f.pc             = b[ES_PC_LSB +: 32];
    f.exe_result     = b[ES_RESULT_LSB +: 32];
    f.dest           = b[ES_DEST_LSB +: 5];
    f.gr_we          = b[ES_GR_WE_BIT];
    f.load_op        = b[ES_LOAD_BIT];
    f.store_op       = b[ES_STORE_BIT];
    f.mem_size       = b[ES_SIZE_LSB +: 2];
    f.excp           = b[ES_EXCP_BIT];
    f.mem_sign_exted = b[ES_SIGN_BIT];
    return f;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline handshake/bus signals around the memory stage.
//   master: exe/writeback side (drives es_to_ms_*, ws_allowin)
//   slave : memory stage (drives ms_allowin, ms_to_ws_*, forward bus, ms_flush)
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_FWD_BUS_WD-1:0]   ms_to_ds_forward_bus;
  logic                       ms_flush;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus, ms_flush
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus, ms_flush
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte/half/word out of a 32-bit read word
// and sign- or zero-extends it.
//   rdata    : raw 32-bit read data
//   addr     : low two address bits
//   mem_size : [0] byte, [1] half, neither = word
//   sign     : 1 = sign-extend byte/half
//   result   : aligned, extended data
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  mem_size,
  input  logic        sign,
  output logic [31:0] result
);
  logic [7:0]  byte_d;
  logic [15:0] half_d;

  assign byte_d = rdata[{addr, 3'b000} +: 8];
  assign half_d = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    if (mem_size[0])
      result = {{24{sign & byte_d[7]}}, byte_d};
    else if (mem_size[1])
      result = {{16{sign & half_d[15]}}, half_d};
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage. Holds one instruction from exe, waits for
// the dcache response of a load/store, aligns load data and passes the result
// to writeback; also drives the decode-stage forward/stall bus.
//   clk, reset     : clock, async active-high reset
//   ms_bus         : exe/writeback handshake and buses (slave side)
//   data_data_ok   : dcache response strobe (one per request, in order)
//   data_rdata     : response data
//   *_flush        : pipeline flush sources
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ms_bus,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic        refetch_flush,
  input  logic        icacop_flush
);
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
  logic [31:0]                rdata_buf;
  logic                       discard;
  ms_state_e                  state, state_n;

  es_fields_t f, f_in;
  logic       flush, accept, need_data, in_need, ms_ready_go, resp_ok;
  logic [31:0] load_src, load_data, final_result;
  logic       fwd_en, dep_need_stall;

  assign f    = es_unpack(es_bus_r);
  assign f_in = es_unpack(ms_bus.es_to_ms_bus);

  assign flush     = excp_flush | ertn_flush | refetch_flush | icacop_flush;
  assign accept    = ms_bus.es_to_ms_valid & ms_bus.ms_allowin;
  assign need_data = ms_valid & (f.load_op | f.store_op) & ~f.excp;
  assign in_need   = (f_in.load_op | f_in.store_op) & ~f_in.excp;
  // A response belongs to the held instruction only when no stale one is owed.
  assign resp_ok   = (state == MS_WAIT) & data_data_ok & ~discard;

  assign ms_ready_go          = ~need_data | (state == MS_HOLD) | resp_ok;
  assign ms_bus.ms_allowin     = ~ms_valid | (ms_ready_go & ms_bus.ws_allowin);
  assign ms_bus.ms_to_ws_valid = ms_valid & ms_ready_go;

  always_comb begin
    state_n = state;
    if (flush)
      state_n = MS_IDLE;
    else if (accept)
      state_n = in_need ? MS_WAIT : MS_IDLE;
    else if (resp_ok)
      state_n = MS_HOLD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= MS_IDLE;
      ms_valid  <= 1'b0;
      es_bus_r  <= '0;
      rdata_buf <= '0;
      discard   <= 1'b0;
    end else begin
      state <= state_n;
      if (flush)
        ms_valid <= 1'b0;
      else if (ms_bus.ms_allowin)
        ms_valid <= ms_bus.es_to_ms_valid;
      if (accept)
        es_bus_r <= ms_bus.es_to_ms_bus;
      if (resp_ok)
        rdata_buf <= data_rdata;
      // The next response is dropped whenever a flushed request is still owed;
      // a response landing in the flush cycle itself settles the debt.
      if (flush && state == MS_WAIT && !resp_ok)
        discard <= 1'b1;
      else if (data_data_ok)
        discard <= 1'b0;
    end
  end

  assign load_src = (state == MS_HOLD) ? rdata_buf : data_rdata;

  load_align u_load_align (
    .rdata    (load_src),
    .addr     (f.exe_result[1:0]),
    .mem_size (f.mem_size),
    .sign     (f.mem_sign_exted),
    .result   (load_data)
  );

  assign final_result   = (f.load_op & ~f.excp) ? load_data : f.exe_result;
  assign fwd_en         = f.gr_we & (f.dest != 5'd0) & ms_valid;
  assign dep_need_stall = ms_valid & f.load_op & ~ms_ready_go;

  assign ms_bus.ms_to_ws_bus         = {f.excp, f.gr_we, f.dest, final_result, f.pc};
  assign ms_bus.ms_to_ds_forward_bus = {dep_need_stall, fwd_en, f.dest, final_result};
  assign ms_bus.ms_flush             = ms_valid & f.excp;

  // Bus bits owned by other stages.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{es_bus_r[74:71], es_bus_r[170:78], es_bus_r[206:172],
                             es_bus_r[214:208], f_in};

  a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
    !(data_data_ok && state == MS_IDLE && !discard))
    else $warning("mem_stage: data_data_ok with no request outstanding, ignored");

endmodule
